// File: rtl/adm1176_bank_model.sv
// Purpose : oversampled I2C target emulating NCH ADM1176 monitors at BASE_ADR..BASE_ADR+NCH-1.
// Latency : 3 clk pin-to-event, sda_oe_o registered 1 clk after the synced SCL edge that opens a bit.
// Backpr. : none; open-drain SDA only, never stretches SCL.
//
// Ports:
//   clk_i, rst_i        model clock, async active-high reset
//   scl_i, sda_i        raw bus levels (synchronised internally)
//   sda_oe_o            1 = pull SDA low
//   mvolts_i, mamps_i   12-bit voltage/current code per channel, channel k at [12k+11:12k]
//   status_i            8-bit status per channel, channel k at [8k+7:8k]
//   cmd_o               last command byte written per channel
//   busy_o              START..STOP window
//   txn_cnt_o           STOPs seen since reset
module adm1176_bank_model #(
  parameter int         NCH             = 4,
  parameter logic [6:0] BASE_ADR        = 7'h48,
  parameter int         CLK_PER_SCL_MIN = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                scl_i,
  input  logic                sda_i,
  output logic                sda_oe_o,
  input  logic [12*NCH-1:0]   mvolts_i,
  input  logic [12*NCH-1:0]   mamps_i,
  input  logic [8*NCH-1:0]    status_i,
  output logic [8*NCH-1:0]    cmd_o,
  output logic                busy_o,
  output logic [31:0]         txn_cnt_o
);

  // The edge detector needs several samples per SCL half-period; channel index is 3 bits.
  if (NCH < 1 || NCH > 8 || CLK_PER_SCL_MIN < 4) begin : g_param_check
    $error("adm1176_bank_model: unsupported parameter set");
  end

  localparam logic [6:0] NCH_W = 7'(NCH);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  // Synchronisers reset to 1 (idle bus) so releasing reset never fakes an edge.
  logic scl_m, scl_s, scl_d, sda_m, sda_s, sda_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      {scl_m, scl_s, scl_d} <= 3'b111;
      {sda_m, sda_s, sda_d} <= 3'b111;
    end else begin
      scl_m <= scl_i;  scl_s <= scl_m;  scl_d <= scl_s;
      sda_m <= sda_i;  sda_s <= sda_m;  sda_d <= sda_s;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  // SCL must be high in both samples so an SCL edge is never mistaken for START/STOP.
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  state_t           state, state_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [6:0]       sr, sr_n;           // previous 7 bits; the 8th comes straight from sda_s
  logic [2:0]       ch, ch_n;
  logic             rw, rw_n;
  logic [1:0]       idx, idx_n;
  logic             first_wr, first_wr_n;
  logic [31:0]      shadow, shadow_n;   // {status, volts, amps} frozen at address ACK
  logic             sda_oe, sda_oe_n;
  logic             busy, busy_n;
  logic [31:0]      txn_cnt, txn_cnt_n;
  logic [8*NCH-1:0] cmd_q, cmd_n;

  logic [6:0] ch_calc;
  logic [7:0] rd_byte;

  assign ch_calc = sr - BASE_ADR;

  always_comb begin
    rd_byte = 8'h00;
    if (cmd_q[int'(ch)*8 + 6])  rd_byte = shadow[31:24];
    else if (idx == 2'd0)       rd_byte = shadow[23:16];
    else if (idx == 2'd1)       rd_byte = shadow[11:4];
    else                        rd_byte = {shadow[15:12], shadow[3:0]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      sr       <= '0;
      ch       <= '0;
      rw       <= 1'b0;
      idx      <= '0;
      first_wr <= 1'b0;
      shadow   <= '0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      txn_cnt  <= '0;
      cmd_q    <= '0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      sr       <= sr_n;
      ch       <= ch_n;
      rw       <= rw_n;
      idx      <= idx_n;
      first_wr <= first_wr_n;
      shadow   <= shadow_n;
      sda_oe   <= sda_oe_n;
      busy     <= busy_n;
      txn_cnt  <= txn_cnt_n;
      cmd_q    <= cmd_n;
    end
  end

  // Bits are sampled on SCL rise; SDA is only changed on SCL fall. Each ACK/data
  // state is entered on a rise, so its first fall opens the slot it owns.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    sr_n       = sr;
    ch_n       = ch;
    rw_n       = rw;
    idx_n      = idx;
    first_wr_n = first_wr;
    shadow_n   = shadow;
    sda_oe_n   = sda_oe;
    busy_n     = busy;
    txn_cnt_n  = txn_cnt;
    cmd_n      = cmd_q;

    if (stop_det) begin
      state_n   = IDLE;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      txn_cnt_n = txn_cnt + 32'd1;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b1;
    end else begin
      unique case (state)
        ADDR: begin
          if (scl_rise) begin
            sr_n      = {sr[5:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              rw_n = sda_s;
              if (ch_calc < NCH_W) begin
                ch_n    = ch_calc[2:0];
                state_n = ADDR_ACK;
              end else begin
                state_n = IGNORE;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b1;
            shadow_n = {status_i[int'(ch)*8 +: 8], mvolts_i[int'(ch)*12 +: 12],
                        mamps_i[int'(ch)*12 +: 12]};
          end else if (scl_rise) begin
            bit_cnt_n  = '0;
            idx_n      = '0;
            first_wr_n = 1'b1;
            state_n    = rw ? RD_DATA : WR_DATA;
          end
        end
        WR_DATA: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
          end else if (scl_rise) begin
            sr_n      = {sr[5:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              state_n = WR_ACK;
              if (first_wr) cmd_n[int'(ch)*8 +: 8] = {sr, sda_s};
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b1;
          end else if (scl_rise) begin
            bit_cnt_n  = '0;
            first_wr_n = 1'b0;
            state_n    = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n = 1'b0;
              state_n  = RD_ACK;
            end else begin
              // ~bit_cnt selects bit 7-bit_cnt, MSB first.
              sda_oe_n = ~rd_byte[~bit_cnt[2:0]];
            end
          end else if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              idx_n     = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
              bit_cnt_n = '0;
              state_n   = RD_DATA;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        default: begin
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe_o  = sda_oe;
  assign busy_o    = busy;
  assign txn_cnt_o = txn_cnt;
  assign cmd_o     = cmd_q;

endmodule

// File: tb/tb_adm1176_bank_model.sv
module tb_adm1176_bank_model;
  localparam int         NCH  = 4;
  localparam logic [6:0] BASE = 7'h48;
  localparam int         H    = 10;   // clk cycles per SCL half-period

  logic                clk = 1'b0;
  logic                rst;
  logic                scl_m, sda_m, sda_bus, sda_oe;
  logic [12*NCH-1:0]   mvolts, mamps;
  logic [8*NCH-1:0]    status, cmd;
  logic                busy;
  logic [31:0]         txn;

  int          checks   = 0;
  int          failures = 0;
  int unsigned oe_cnt   = 0;

  logic [7:0]  m_cmd [NCH];
  int unsigned m_txn;

  always #5 clk = ~clk;
  assign sda_bus = sda_m & ~sda_oe;
  always @(posedge clk) if (sda_oe) oe_cnt <= oe_cnt + 1;

  adm1176_bank_model #(.NCH(NCH), .BASE_ADR(BASE), .CLK_PER_SCL_MIN(8)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe_o(sda_oe),
    .mvolts_i(mvolts), .mamps_i(mamps), .status_i(status), .cmd_o(cmd),
    .busy_o(busy), .txn_cnt_o(txn)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: byte k of a read, from the channel's command and frozen inputs.
  function automatic logic [7:0] model_byte(input logic [7:0] c, input int k,
      input logic [11:0] v, input logic [11:0] i, input logic [7:0] st);
    if (c[6]) return st;
    case (k % 3)
      0:       return v[11:4];
      1:       return i[11:4];
      default: return {v[3:0], i[3:0]};
    endcase
  endfunction

  function automatic logic [8*NCH-1:0] model_cmd_vec();
    logic [8*NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*8 +: 8] = m_cmd[c];
    return r;
  endfunction

  task automatic wclk(input int n); repeat (n) @(negedge clk); endtask

  task automatic set_ch(input int c, input logic [11:0] v, input logic [11:0] i, input logic [7:0] st);
    mvolts[c*12 +: 12] = v;
    mamps[c*12 +: 12]  = i;
    status[c*8 +: 8]   = st;
  endtask

  task automatic i2c_start();
    wclk(H/2); sda_m = 1'b1; wclk(H/2); scl_m = 1'b1; wclk(H);
    sda_m = 1'b0; wclk(H); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wclk(H/2); sda_m = 1'b0; wclk(H/2); scl_m = 1'b1; wclk(H);
    sda_m = 1'b1; wclk(H);
  endtask

  task automatic wr_bit(input logic b);
    wclk(H/2); sda_m = b; wclk(H/2); scl_m = 1'b1; wclk(H); scl_m = 1'b0;
  endtask

  task automatic rd_bit(output logic b);
    wclk(H/2); sda_m = 1'b1; wclk(H/2); scl_m = 1'b1; wclk(H/2);
    b = sda_bus; wclk(H/2); scl_m = 1'b0;
  endtask

  // Returns the raw 9th-bit level: 0 = ACK.
  task automatic wr_byte(input logic [7:0] d, output logic a);
    for (int k = 7; k >= 0; k--) wr_bit(d[k]);
    rd_bit(a);
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = 8'h00;
    for (int k = 0; k < 8; k++) begin rd_bit(b); d = {d[6:0], b}; end
    wr_bit(nack);
  endtask

  task automatic xfer_read(input logic [6:0] adr, input int nb, output logic ack, output logic [39:0] got);
    logic a; logic [7:0] d;
    got = '0;
    i2c_start();
    wr_byte({adr, 1'b1}, a);
    ack = ~a;
    if (!a) for (int k = 0; k < nb; k++) begin
      rd_byte(d, k == nb - 1);
      got = {got[31:0], d};
    end
    i2c_stop();
  endtask

  task automatic xfer_write(input logic [6:0] adr, input int nb, input logic [15:0] wd,
      output logic ack, output logic dack);
    logic a;
    dack = 1'b1;
    i2c_start();
    wr_byte({adr, 1'b0}, a);
    ack = ~a;
    if (!a) for (int k = 0; k < nb; k++) begin
      wr_byte(wd[15-8*k -: 8], a);
      if (a) dack = 1'b0;
    end
    i2c_stop();
  endtask

  typedef struct {
    bit          rd;
    logic [6:0]  adr;
    int          nb;
    logic [15:0] wd;
    logic [11:0] v;
    logic [11:0] i;
    logic [7:0]  st;
    bit          ack;
    logic [39:0] exp;      // read bytes, right-aligned, first byte most significant
    logic [7:0]  cmd_exp;  // expected cmd of the addressed channel after a write
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic        ack, dack, b, found;
    logic [39:0] got;
    logic [7:0]  d;
    logic [6:0]  adr;
    int          c, nb;
    int unsigned oe0;
    logic [15:0] wd;
    logic [11:0] rv [NCH];
    logic [11:0] ri [NCH];
    logic [7:0]  rs [NCH];

    tbl[0] = '{1'b1, 7'h48, 3, 16'h0,    12'hCE4, 12'h064, 8'h00, 1'b1, 40'hCE0644,     8'h00};
    tbl[1] = '{1'b1, 7'h4A, 5, 16'h0,    12'h123, 12'h456, 8'h00, 1'b1, 40'h1245361245, 8'h00};
    tbl[2] = '{1'b0, 7'h49, 1, 16'h4000, 12'h000, 12'h000, 8'h00, 1'b1, 40'h0,          8'h40};
    tbl[3] = '{1'b1, 7'h49, 2, 16'h0,    12'h777, 12'h888, 8'hA5, 1'b1, 40'hA5A5,       8'h00};
    tbl[4] = '{1'b1, 7'h4C, 1, 16'h0,    12'h000, 12'h000, 8'h00, 1'b0, 40'h0,          8'h00};
    tbl[5] = '{1'b0, 7'h4B, 2, 16'h4000, 12'h000, 12'h000, 8'h00, 1'b1, 40'h0,          8'h40};
    tbl[6] = '{1'b1, 7'h4B, 2, 16'h0,    12'h321, 12'h654, 8'h3C, 1'b1, 40'h3C3C,       8'h00};
    tbl[7] = '{1'b1, 7'h47, 1, 16'h0,    12'h000, 12'h000, 8'h00, 1'b0, 40'h0,          8'h00};
    tbl[8] = '{1'b0, 7'h4A, 1, 16'h1300, 12'h000, 12'h000, 8'h00, 1'b1, 40'h0,          8'h13};
    tbl[9] = '{1'b1, 7'h4A, 3, 16'h0,    12'hFFF, 12'h000, 8'h00, 1'b1, 40'hFF00F0,     8'h00};

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    mvolts = '0; mamps = '0; status = '0;
    for (int k = 0; k < NCH; k++) m_cmd[k] = 8'h00;
    m_txn = 0;
    wclk(5);
    rst = 1'b0;
    wclk(5);

    chk("reset_sda_oe", 40'(sda_oe), 40'h0);
    chk("reset_busy",   40'(busy),   40'h0);
    chk("reset_txn",    40'(txn),    40'h0);
    chk("reset_cmd",    40'(cmd),    40'h0);

    // ---------------- table-driven transactions ----------------
    for (int r = 0; r < 10; r++) begin
      c = int'(7'(tbl[r].adr - BASE));
      if (c < NCH) set_ch(c, tbl[r].v, tbl[r].i, tbl[r].st);
      if (tbl[r].rd) begin
        xfer_read(tbl[r].adr, tbl[r].nb, ack, got);
        chk($sformatf("tbl%0d_ack", r), 40'(ack), 40'(tbl[r].ack));
        chk($sformatf("tbl%0d_bytes", r), got, tbl[r].exp);
      end else begin
        xfer_write(tbl[r].adr, tbl[r].nb, tbl[r].wd, ack, dack);
        chk($sformatf("tbl%0d_ack", r), 40'(ack), 40'(tbl[r].ack));
        chk($sformatf("tbl%0d_dack", r), 40'(dack), 40'h1);
        chk($sformatf("tbl%0d_cmd", r), 40'(cmd[c*8 +: 8]), 40'(tbl[r].cmd_exp));
        m_cmd[c] = tbl[r].wd[15:8];
      end
      m_txn++;
      chk($sformatf("tbl%0d_txn", r), 40'(txn), 40'(m_txn));
      chk($sformatf("tbl%0d_busy", r), 40'(busy), 40'h0);
    end

    // ---------------- unmatched address: never drives SDA ----------------
    oe0 = oe_cnt;
    i2c_start();
    wclk(2);
    chk("noack_busy_after_start", 40'(busy), 40'h1);
    wr_byte({7'h4C, 1'b1}, b);
    chk("noack_level", 40'(b), 40'h1);
    wr_bit(1'b1);
    chk("noack_busy_mid", 40'(busy), 40'h1);
    i2c_stop();
    m_txn++;
    chk("noack_oe_quiet", 40'(oe_cnt - oe0), 40'h0);
    chk("noack_busy_after_stop", 40'(busy), 40'h0);
    chk("noack_txn", 40'(txn), 40'(m_txn));

    // ---------------- inputs change mid-read: snapshot holds ----------------
    set_ch(2, 12'h123, 12'h456, 8'h00);
    i2c_start();
    wr_byte({7'h4A, 1'b1}, b);
    chk("snap_ack", 40'(b), 40'h0);
    rd_byte(d, 1'b0);
    chk("snap_b0", 40'(d), 40'h12);
    d = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) set_ch(2, 12'hABC, 12'hDEF, 8'h00);
      rd_bit(b);
      d = {d[6:0], b};
    end
    wr_bit(1'b0);
    chk("snap_b1", 40'(d), 40'h45);
    rd_byte(d, 1'b1);
    chk("snap_b2", 40'(d), 40'h36);
    i2c_stop();
    m_txn++;
    chk("snap_txn", 40'(txn), 40'(m_txn));

    // ---------------- write cmd, repeated START, read ----------------
    set_ch(0, 12'h9A5, 12'h111, 8'h77);
    xfer_write(7'h48, 1, 16'h4000, ack, dack);   // status mode first, so clearing it matters
    m_cmd[0] = 8'h40; m_txn++;
    i2c_start();
    wr_byte({7'h48, 1'b0}, b);
    chk("rs_addr_ack", 40'(b), 40'h0);
    wr_byte(8'h00, b);
    chk("rs_data_ack", 40'(b), 40'h0);
    m_cmd[0] = 8'h00;
    chk("rs_cmd", 40'(cmd[7:0]), 40'h00);
    i2c_start();
    chk("rs_busy", 40'(busy), 40'h1);
    wr_byte({7'h48, 1'b1}, b);
    chk("rs_rd_ack", 40'(b), 40'h0);
    rd_byte(d, 1'b1);
    chk("rs_byte", 40'(d), 40'(model_byte(m_cmd[0], 0, 12'h9A5, 12'h111, 8'h77)));
    i2c_stop();
    m_txn++;
    chk("rs_txn", 40'(txn), 40'(m_txn));

    // ---------------- reset while driving SDA ----------------
    set_ch(0, 12'hCE4, 12'h064, 8'h00);
    i2c_start();
    wr_byte({7'h48, 1'b1}, b);
    rd_bit(b);
    rd_bit(b);            // 0xCE: bits 7,6 are 1, bit 5 is 0 -> DUT drives
    found = 1'b0;
    for (int n = 0; n < 2*H && !found; n++) begin
      @(negedge clk);
      if (sda_oe) found = 1'b1;
    end
    chk("rst_pre_oe", 40'(found), 40'h1);
    rst = 1'b1;
    #1;
    chk("rst_oe_now", 40'(sda_oe), 40'h0);
    chk("rst_busy",   40'(busy),   40'h0);
    chk("rst_txn",    40'(txn),    40'h0);
    chk("rst_cmd",    40'(cmd),    40'h0);
    sda_m = 1'b1;
    wclk(2);
    scl_m = 1'b1;
    wclk(4);
    rst = 1'b0;
    wclk(H);
    for (int k = 0; k < NCH; k++) m_cmd[k] = 8'h00;
    m_txn = 0;
    xfer_read(7'h48, 3, ack, got);
    m_txn++;
    chk("post_rst_ack",   40'(ack), 40'h1);
    chk("post_rst_bytes", got, 40'hCE0644);
    chk("post_rst_txn",   40'(txn), 40'h1);

    // ---------------- randomized traffic vs reference model ----------------
    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < NCH; k++) begin
        rv[k] = 12'($urandom);
        ri[k] = 12'($urandom);
        rs[k] = 8'($urandom);
        set_ch(k, rv[k], ri[k], rs[k]);
      end
      adr = 7'h46 + 7'($urandom_range(0, 8));
      c   = int'(7'(adr - BASE));
      if ($urandom_range(0, 1) == 1) begin
        nb = $urandom_range(1, 4);
        xfer_read(adr, nb, ack, got);
        chk($sformatf("rnd%0d_ack", t), 40'(ack), 40'(c < NCH));
        if (c < NCH) for (int k = 0; k < nb; k++)
          chk($sformatf("rnd%0d_byte%0d", t, k), 40'(got[8*(nb-1-k) +: 8]),
              40'(model_byte(m_cmd[c], k, rv[c], ri[c], rs[c])));
      end else begin
        nb = $urandom_range(1, 2);
        wd = 16'($urandom);
        xfer_write(adr, nb, wd, ack, dack);
        chk($sformatf("rnd%0d_ack", t), 40'(ack), 40'(c < NCH));
        if (c < NCH) begin
          chk($sformatf("rnd%0d_dack", t), 40'(dack), 40'h1);
          m_cmd[c] = wd[15:8];
        end
      end
      m_txn++;
      chk($sformatf("rnd%0d_txn", t), 40'(txn), 40'(m_txn));
      chk($sformatf("rnd%0d_cmd", t), 40'(cmd), 40'(model_cmd_vec()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
